// File: rtl/pitch_count_ctrl.sv
// pitch_count_ctrl: button conditioning, count, inning/half state, base-advance pulse and clear
module pitch_count_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       iCLK,
  input  logic       iRSTn,
  input  logic       iBALL,
  input  logic       iSTRIKE,
  input  logic       iFOUL,
  input  logic       iHIT,
  input  logic       iOUT,
  output logic [2:0] oBALL,
  output logic [1:0] oSTRIKE,
  output logic [1:0] oOUT,
  output logic       oBASE_ADV,
  output logic       oCLEAR_n,
  output logic [3:0] oINNING,
  output logic       oHALF,
  output logic       oGAME
);
  localparam logic [1:0] PLAY      = 2'd0;
  localparam logic [1:0] CHANGE    = 2'd1;
  localparam logic [1:0] GAME_OVER = 2'd2;
  logic [1:0] state;
  logic [SYNC_STAGES-1:0][4:0] sync;
  logic [4:0] hist;
  logic [4:0] ev;
  logic play, do_out, do_hit, do_ball, do_strike, do_foul;
  logic walk, any_out, third, clr_count;
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      sync <= '0;
      hist <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], {iOUT, iHIT, iBALL, iSTRIKE, iFOUL}};
      hist <= sync[SYNC_STAGES-1];
    end
  end
  assign ev        = sync[SYNC_STAGES-1] & ~hist;
  assign play      = state == PLAY;
  assign do_out    = play && ev[4];
  assign do_hit    = play && !ev[4] && ev[3];
  assign do_ball   = play && ev[4:3] == 2'b00 && ev[2];
  assign do_strike = play && ev[4:2] == 3'b000 && ev[1];
  assign do_foul   = play && ev[4:1] == 4'b0000 && ev[0];
  assign walk      = do_ball && oBALL[2];
  assign any_out   = do_out || (do_strike && oSTRIKE[1]);
  assign third     = any_out && oOUT[1];
  assign clr_count = walk || do_hit || any_out;
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state     <= PLAY;
      oBALL     <= '0;
      oSTRIKE   <= '0;
      oOUT      <= '0;
      oBASE_ADV <= 1'b0;
      oCLEAR_n  <= 1'b1;
      oINNING   <= 4'd1;
      oHALF     <= 1'b0;
      oGAME     <= 1'b0;
    end else begin
      oBASE_ADV <= walk || do_hit;
      oCLEAR_n  <= !third;
      if (state == CHANGE) begin
        oBALL   <= '0;
        oSTRIKE <= '0;
        oOUT    <= '0;
        if (!oHALF) begin
          oHALF <= 1'b1;
          state <= PLAY;
        end else if (oINNING < 4'd9) begin
          oHALF   <= 1'b0;
          oINNING <= oINNING + 4'd1;
          state   <= PLAY;
        end else begin
          oGAME <= 1'b1;
          state <= GAME_OVER;
        end
      end else begin
        if (clr_count) begin
          oBALL   <= '0;
          oSTRIKE <= '0;
        end else if (do_ball) begin
          oBALL <= {oBALL[1:0], 1'b1};
        end else if ((do_strike || do_foul) && !oSTRIKE[1]) begin
          oSTRIKE <= {oSTRIKE[0], 1'b1};
        end
        if (any_out)
          oOUT <= {oOUT[0], 1'b1};
        if (third)
          state <= CHANGE;
      end
    end
  end
endmodule

// File: tb/tb_pitch_count_ctrl.sv
// tb_pitch_count_ctrl: scoreboarded directed test of pitch_count_ctrl
module tb_pitch_count_ctrl;
  logic       iCLK = 1'b0;
  logic       iRSTn = 1'b0;
  logic       iBALL = 1'b0, iSTRIKE = 1'b0, iFOUL = 1'b0, iHIT = 1'b0, iOUT = 1'b0;
  logic [2:0] oBALL;
  logic [1:0] oSTRIKE, oOUT;
  logic       oBASE_ADV, oCLEAR_n, oHALF, oGAME;
  logic [3:0] oINNING;
  localparam logic [4:0] B_OUT = 5'b10000, B_HIT = 5'b01000, B_BALL = 5'b00100,
                         B_STK = 5'b00010, B_FOUL = 5'b00001;
  typedef struct packed {
    int          due;
    logic [14:0] val;
    logic [79:0] nm;
  } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  pitch_count_ctrl #(.SYNC_STAGES(2)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iBALL(iBALL), .iSTRIKE(iSTRIKE), .iFOUL(iFOUL),
    .iHIT(iHIT), .iOUT(iOUT), .oBALL(oBALL), .oSTRIKE(oSTRIKE), .oOUT(oOUT),
    .oBASE_ADV(oBASE_ADV), .oCLEAR_n(oCLEAR_n), .oINNING(oINNING), .oHALF(oHALF),
    .oGAME(oGAME)
  );
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;
  always @(negedge iCLK) begin
    exp_t e;
    logic [14:0] got;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      got = {oBALL, oSTRIKE, oOUT, oBASE_ADV, oCLEAR_n, oINNING, oHALF, oGAME};
      total++;
      if (e.due == cyc && got == e.val)
        passed++;
      else
        $display("FAIL %0s: got %b want %b (cycle %0d due %0d)", e.nm, got, e.val, cyc, e.due);
    end
  end
  function automatic int therm(input int n);
    return (1 << n) - 1;
  endfunction
  task automatic chk(input int d, input int b, input int s, input int o, input logic adv,
                     input logic clr, input int inn, input logic half, input logic game,
                     input logic [79:0] nm);
    exp_t e;
    e.due = cyc + d;
    e.val = {3'(therm(b)), 2'(therm(s)), 2'(therm(o)), adv, clr, 4'(inn), half, game};
    e.nm  = nm;
    sb.push_back(e);
  endtask
  task automatic press(input logic [4:0] m);
    {iOUT, iHIT, iBALL, iSTRIKE, iFOUL} = m;
    @(negedge iCLK);
    {iOUT, iHIT, iBALL, iSTRIKE, iFOUL} = 5'b0;
  endtask
  task automatic go();
    repeat (3) @(negedge iCLK);
  endtask
  initial begin
    repeat (2) @(negedge iCLK);
    iRSTn = 1'b1;
    chk(1, 0, 0, 0, 0, 1, 1, 0, 0, "reset");
    go();
    press(B_BALL);
    chk(1, 0, 0, 0, 0, 1, 1, 0, 0, "ball_lat");
    chk(2, 1, 0, 0, 0, 1, 1, 0, 0, "ball1");
    go();
    press(B_BALL); chk(2, 2, 0, 0, 0, 1, 1, 0, 0, "ball2"); go();
    press(B_BALL); chk(2, 3, 0, 0, 0, 1, 1, 0, 0, "ball3"); go();
    total++;
    if (oBALL == 3'b111) passed++;
    else $display("FAIL d_ball3: oBALL=%b", oBALL);
    press(B_BALL);
    chk(2, 0, 0, 0, 1, 1, 1, 0, 0, "walk");
    chk(3, 0, 0, 0, 0, 1, 1, 0, 0, "walk_end");
    go();
    press(B_STK); chk(2, 0, 1, 0, 0, 1, 1, 0, 0, "strike1"); go();
    press(B_STK); chk(2, 0, 2, 0, 0, 1, 1, 0, 0, "strike2"); go();
    for (int i = 0; i < 3; i++) begin
      press(B_FOUL); chk(2, 0, 2, 0, 0, 1, 1, 0, 0, "foul2k"); go();
    end
    total++;
    if (oSTRIKE == 2'b11) passed++;
    else $display("FAIL d_foul: oSTRIKE=%b", oSTRIKE);
    press(B_STK); chk(2, 0, 0, 1, 0, 1, 1, 0, 0, "k_out"); go();
    press(B_OUT); chk(2, 0, 0, 2, 0, 1, 1, 0, 0, "out2"); go();
    press(B_OUT);
    chk(2, 0, 0, 2, 0, 0, 1, 0, 0, "third");
    chk(3, 0, 0, 0, 0, 1, 1, 1, 0, "change");
    press(B_BALL);
    chk(2, 0, 0, 0, 0, 1, 1, 1, 0, "ign_chg");
    chk(3, 0, 0, 0, 0, 1, 1, 1, 0, "ign_chg2");
    go();
    press(B_BALL); chk(2, 1, 0, 0, 0, 1, 1, 1, 0, "ball_b1"); go();
    press(B_HIT | B_BALL);
    chk(2, 0, 0, 0, 1, 1, 1, 1, 0, "hit_win");
    chk(3, 0, 0, 0, 0, 1, 1, 1, 0, "one_pulse");
    go();
    total++;
    if (oBALL == 3'b000 && !oBASE_ADV) passed++;
    else $display("FAIL d_hit: oBALL=%b adv=%b", oBALL, oBASE_ADV);
    for (int j = 1; j <= 16; j++) begin
      press(B_OUT); go();
      press(B_OUT); go();
      press(B_OUT);
      chk(2, 0, 0, 2, 0, 0, j / 2 + 1, 1'(j % 2), 0, "3rd_out");
      chk(3, 0, 0, 0, 0, 1, (j + 1) / 2 + 1, 1'((j + 1) % 2), 0, "half_chg");
      go();
    end
    press(B_OUT); go();
    press(B_OUT); go();
    press(B_OUT);
    chk(2, 0, 0, 2, 0, 0, 9, 1, 0, "final_out");
    chk(3, 0, 0, 0, 0, 1, 9, 1, 1, "game_over");
    go();
    total++;
    if (oGAME) passed++;
    else $display("FAIL d_game: oGAME=%b", oGAME);
    press(B_BALL); chk(2, 0, 0, 0, 0, 1, 9, 1, 1, "go_ball"); go();
    press(B_HIT);  chk(2, 0, 0, 0, 0, 1, 9, 1, 1, "go_hit");  go();
    press(B_OUT);  chk(2, 0, 0, 0, 0, 1, 9, 1, 1, "go_out");  go();
    press(B_STK);  chk(2, 0, 0, 0, 0, 1, 9, 1, 1, "go_stk");  go();
    iRSTn = 1'b0;
    chk(1, 0, 0, 0, 0, 1, 1, 0, 0, "rst_game");
    @(negedge iCLK);
    iRSTn = 1'b1;
    chk(1, 0, 0, 0, 0, 1, 1, 0, 0, "rst_rel");
    go();
    iSTRIKE = 1'b1;
    chk(1, 0, 0, 0, 0, 1, 1, 0, 0, "hold_e1");
    chk(2, 0, 0, 0, 0, 1, 1, 0, 0, "hold_e2");
    chk(3, 0, 1, 0, 0, 1, 1, 0, 0, "hold_e3");
    repeat (20) @(negedge iCLK);
    chk(1, 0, 1, 0, 0, 1, 1, 0, 0, "hold_end");
    iSTRIKE = 1'b0;
    go();
    press(B_OUT); go();
    press(B_OUT); go();
    press(B_OUT);
    chk(2, 0, 0, 2, 0, 0, 1, 0, 0, "third_r");
    repeat (2) @(negedge iCLK);
    #2 iRSTn = 1'b0;
    #2 iRSTn = 1'b1;
    chk(1, 0, 0, 0, 0, 1, 1, 0, 0, "rst_chg");
    chk(2, 0, 0, 0, 0, 1, 1, 0, 0, "rst_chg2");
    go();
    press(B_BALL); chk(2, 1, 0, 0, 0, 1, 1, 0, 0, "post_rst"); go();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge iCLK);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      $display("FAIL %0s: never compared (due %0d, now %0d)", e.nm, e.due, cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
